// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential multiplier.
package mul_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_mul32_cia_adder.sv
// 32-bit carry-increment adder: 4-bit ripple blocks, each conditionally
// incremented by the carry from the block below.
module seq_mul32_cia_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout,
  output logic        ovf
);

  localparam int unsigned BLK  = 4;
  localparam int unsigned NBLK = 8;

  logic [NBLK:0] c;

  assign c[0] = cin;

  for (genvar g = 0; g < NBLK; g++) begin : g_blk
    logic [BLK:0]   raw;
    logic [BLK-1:0] inc;

    assign raw = (BLK+1)'(a[g*BLK +: BLK]) + (BLK+1)'(b[g*BLK +: BLK]);
    assign inc = raw[BLK-1:0] + BLK'(1);
    assign sum[g*BLK +: BLK] = c[g] ? inc : raw[BLK-1:0];
    // Block carries out if it generated one, or propagates an incoming one.
    assign c[g+1] = raw[BLK] | (c[g] & (&raw[BLK-1:0]));
  end

  assign cout = c[NBLK];
  assign ovf  = (a[31] ~^ b[31]) & (sum[31] ^ a[31]);

endmodule

// File: rtl/seq_mul32.sv
// Unsigned 32x32 -> 64 shift-and-add multiplier, one adder pass per cycle,
// valid/ready on both operand and product sides.
module seq_mul32
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH       = mul_pkg::WIDTH,
  parameter bit          ZERO_BYPASS = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 busy
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   p_hi_q, p_hi_d;
  logic [WIDTH-1:0]   p_lo_q, p_lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               in_ready_d;
  logic               out_valid_d;
  logic               busy_d;
  logic [2*WIDTH-1:0] out_p_d;

  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_s;
  logic               add_c;
  logic               unused_ovf;

  // Partial-product select: add the multiplicand only when the current multiplier bit is set.
  assign add_b = p_lo_q[0] ? m_q : '0;

  seq_mul32_cia_adder u_add (
    .a    (p_hi_q),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_s),
    .cout (add_c),
    .ovf  (unused_ovf)
  );

  // Next-state, datapath update and registered-output decode.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d    = in_a;
          p_hi_d = '0;
          p_lo_d = in_b;
          cnt_d  = '0;
          if (ZERO_BYPASS && ((in_a == '0) || (in_b == '0))) begin
            p_lo_d  = '0;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // Carry-out lands in the product MSB so no bits are lost.
        {p_hi_d, p_lo_d} = {add_c, add_s, p_lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == RUN);
    out_p_d     = out_valid_d ? {p_hi_d, p_lo_d} : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= '0;
      p_hi_q    <= '0;
      p_lo_q    <= '0;
      cnt_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_p     <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      p_hi_q    <= p_hi_d;
      p_lo_q    <= p_lo_d;
      cnt_q     <= cnt_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
      out_p     <= out_p_d;
    end
  end

endmodule

// File: tb/tb_seq_mul32.sv
// Randomized self-checking bench for seq_mul32 against a plain multiply model.
module tb_seq_mul32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_p;
  logic        busy;

  logic        nb_in_valid = 1'b0;
  logic        nb_in_ready;
  logic [31:0] nb_in_a = '0;
  logic [31:0] nb_in_b = '0;
  logic        nb_out_valid;
  logic        nb_out_ready = 1'b0;
  logic [63:0] nb_out_p;
  logic        nb_busy;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  seq_mul32 #(.WIDTH(32), .ZERO_BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .busy(busy)
  );

  seq_mul32 #(.WIDTH(32), .ZERO_BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(nb_in_valid), .in_ready(nb_in_ready), .in_a(nb_in_a), .in_b(nb_in_b),
    .out_valid(nb_out_valid), .out_ready(nb_out_ready), .out_p(nb_out_p), .busy(nb_busy)
  );

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

  // Present operands until accepted; returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      in_a = a; in_b = b; in_valid = 1'b1;
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (ok) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (!out_valid && edges < 200) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, out_p} !== {1'b1, 1'b0, 1'b0, 64'h0})
      $display("FAIL reset_state: rdy/vld/busy/p=%b/%b/%b/%h want 1/0/0/0", in_ready, out_valid, busy, out_p);
    else passes++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, nb_in_ready, nb_out_valid} !== 5'b10010)
      $display("FAIL post_reset_idle: got %b want 10010", {in_ready, out_valid, busy, nb_in_ready, nb_out_valid});
    else passes++;
  endtask

  task automatic test_basic();
    bit ok; int edges; int busy_cnt;
    send(32'd3, 32'd5, ok);
    checks++;
    if (!ok) $display("FAIL basic_accept: in_ready never seen high"); else passes++;
    edges = 0; busy_cnt = 0;
    while (!out_valid && edges < 200) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      edges++;
    end
    checks++;
    if (edges !== 32) $display("FAIL basic_latency: got %0d edges want 32", edges); else passes++;
    checks++;
    if (busy_cnt !== 32) $display("FAIL basic_busy_cycles: got %0d want 32", busy_cnt); else passes++;
    checks++;
    if (out_p !== ref_mul(32'd3, 32'd5)) $display("FAIL basic_product: got %h want %h", out_p, ref_mul(32'd3, 32'd5)); else passes++;
    take();
    checks++;
    if ({in_ready, out_valid, busy, out_p} !== {1'b1, 1'b0, 1'b0, 64'h0})
      $display("FAIL basic_after_take: rdy/vld/busy/p=%b/%b/%b/%h want 1/0/0/0", in_ready, out_valid, busy, out_p);
    else passes++;
  endtask

  task automatic test_all_ones();
    bit ok; int edges;
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, ok);
    wait_valid(edges);
    checks++;
    if (!ok || out_valid !== 1'b1) $display("FAIL ones_valid: ok=%0d out_valid=%b want 1/1", ok, out_valid); else passes++;
    checks++;
    if (out_p !== ref_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF))
      $display("FAIL ones_product: got %h want %h", out_p, ref_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF));
    else passes++;
    take();
  endtask

  task automatic test_bypass();
    bit ok; int edges; int nb_busy_cnt;
    send(32'h0, 32'h1234_5678, ok);
    checks++;
    if ({ok, out_valid, busy, out_p} !== {1'b1, 1'b1, 1'b0, 64'h0})
      $display("FAIL bypass_a0: ok/vld/busy/p=%b/%b/%b/%h want 1/1/0/0", ok, out_valid, busy, out_p);
    else passes++;
    take();
    send(32'hDEAD_BEEF, 32'h0, ok);
    checks++;
    if ({ok, out_valid, busy, out_p} !== {1'b1, 1'b1, 1'b0, 64'h0})
      $display("FAIL bypass_b0: ok/vld/busy/p=%b/%b/%b/%h want 1/1/0/0", ok, out_valid, busy, out_p);
    else passes++;
    take();

    // Same zero operand on the instance without the bypass takes the full iteration count.
    @(negedge clk);
    checks++;
    if (nb_in_ready !== 1'b1) $display("FAIL nobypass_ready: got %b want 1", nb_in_ready); else passes++;
    nb_in_a = 32'h0; nb_in_b = 32'h1234_5678; nb_in_valid = 1'b1;
    @(negedge clk);
    nb_in_valid = 1'b0;
    edges = 0; nb_busy_cnt = 0;
    while (!nb_out_valid && edges < 200) begin
      if (nb_busy) nb_busy_cnt++;
      @(negedge clk);
      edges++;
    end
    checks++;
    if (edges !== 32 || nb_busy_cnt !== 32)
      $display("FAIL nobypass_latency: edges=%0d busy=%0d want 32/32", edges, nb_busy_cnt);
    else passes++;
    checks++;
    if (nb_out_p !== 64'h0) $display("FAIL nobypass_product: got %h want 0", nb_out_p); else passes++;
    nb_out_ready = 1'b1;
    @(negedge clk);
    nb_out_ready = 1'b0;
    checks++;
    if (nb_out_valid !== 1'b0) $display("FAIL nobypass_take: out_valid=%b want 0", nb_out_valid); else passes++;
  endtask

  task automatic test_backpressure();
    bit ok; int edges; int bad_ready; int bad_hold;
    logic [63:0] exp;
    exp = ref_mul(32'h8000_0001, 32'h0000_0002);
    send(32'h8000_0001, 32'h0000_0002, ok);
    bad_ready = 0;
    repeat (5) begin
      @(negedge clk);
      if (in_ready !== 1'b0) bad_ready++;
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom | 32'h1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (bad_ready !== 0) $display("FAIL run_ready_low: in_ready high %0d times in RUN, want 0", bad_ready); else passes++;
    wait_valid(edges);
    checks++;
    if (out_valid !== 1'b1) $display("FAIL bp_valid: out_valid=%b want 1", out_valid); else passes++;
    bad_hold = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || out_p !== exp || in_ready !== 1'b0) bad_hold++;
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom | 32'h1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (bad_hold !== 0 || out_p !== exp)
      $display("FAIL bp_hold: %0d unstable cycles, out_p=%h want %h", bad_hold, out_p, exp);
    else passes++;
    take();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) $display("FAIL bp_after_take: rdy/vld=%b want 10", {in_ready, out_valid}); else passes++;
    send(32'd6, 32'd7, ok);
    wait_valid(edges);
    checks++;
    if (edges !== 32 || out_p !== ref_mul(32'd6, 32'd7))
      $display("FAIL bp_next_op: edges=%0d p=%h want 32/%h", edges, out_p, ref_mul(32'd6, 32'd7));
    else passes++;
    take();
  endtask

  task automatic test_reset_abort();
    bit ok; int edges; int spurious;
    send(32'd7, 32'd9, ok);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({in_ready, out_valid, busy, out_p} !== {1'b1, 1'b0, 1'b0, 64'h0})
      $display("FAIL abort_state: rdy/vld/busy/p=%b/%b/%b/%h want 1/0/0/0", in_ready, out_valid, busy, out_p);
    else passes++;
    spurious = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) spurious++;
    end
    checks++;
    if (spurious !== 0) $display("FAIL abort_no_output: %0d active cycles want 0", spurious); else passes++;
    send(32'd7, 32'd9, ok);
    wait_valid(edges);
    checks++;
    if (edges !== 32 || out_p !== ref_mul(32'd7, 32'd9))
      $display("FAIL abort_rerun: edges=%0d p=%h want 32/%h", edges, out_p, ref_mul(32'd7, 32'd9));
    else passes++;
    take();
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_q[$];
    logic [63:0] exp;
    logic [31:0] a, b;
    bit ok; int edges; int stall; int want_lat; int bad_hold;
    for (int n = 0; n < 10; n++) begin
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 4) == 0) a = '0;
      if ($urandom_range(0, 4) == 0) b = '0;
      exp_q.push_back(ref_mul(a, b));
      want_lat = (a == '0 || b == '0) ? 0 : 32;
      send(a, b, ok);
      wait_valid(edges);
      exp = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || edges !== want_lat)
        $display("FAIL b2b_latency[%0d]: vld=%b edges=%0d want 1/%0d", n, out_valid, edges, want_lat);
      else passes++;
      stall = $urandom_range(0, 5);
      bad_hold = 0;
      repeat (stall) begin
        if (out_p !== exp || out_valid !== 1'b1) bad_hold++;
        @(negedge clk);
      end
      checks++;
      if (out_p !== exp || bad_hold !== 0)
        $display("FAIL b2b_product[%0d]: a=%h b=%h got %h want %h (unstable %0d)", n, a, b, out_p, exp, bad_hold);
      else passes++;
      take();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_ones();
    test_bypass();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seq_mul32.md
Name: seq_mul32

Overview:
- Unsigned 32x32 -> 64-bit sequential shift-and-add multiplier.
- Consumes the team's existing 32-bit carry-increment adder: one add per cycle, using its sum and carry-out.
- Operands arrive on a valid/ready input handshake; the product leaves on a valid/ready output handshake.
- Sits downstream of the adder library as the first multicycle arithmetic unit in the datapath.

Parameters:
- WIDTH, 32, operand width; only 32 is supported because the adder is fixed at 32 bits.
- ZERO_BYPASS, 1, when 1 a zero operand skips the iterations and yields product 0.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- in_a  input  WIDTH  multiplicand.
- in_b  input  WIDTH  multiplier.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- out_p  output  2*WIDTH  product.
- busy  output  1  high in RUN.

Behaviour:
- Reset (rst_n low at a rising edge):
  - state=IDLE, in_ready=1, out_valid=0, busy=0, out_p=0, iteration counter=0, internal registers=0.
  - Reset mid-RUN or mid-DONE aborts the operation; no product is emitted.
- Registers: M (WIDTH), P_hi (WIDTH), P_lo (WIDTH), cnt (6 bits).
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, capture M=in_a, P_lo=in_b, P_hi=0, cnt=0.
  - If ZERO_BYPASS=1 and (in_a==0 or in_b==0): go to DONE with {P_hi,P_lo}=0.
  - Otherwise go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Adder inputs: a=P_hi, b=(P_lo[0] ? M : 0); sum S, carry C.
  - Each edge: {P_hi,P_lo} <= {C, S, P_lo[WIDTH-1:1]}, cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1 (the 32nd iteration), go to DONE.
- DONE:
  - out_valid=1, out_p={P_hi,P_lo}; both held stable while out_ready=0 (backpressure of any length).
  - On an edge with out_ready=1, go to IDLE and clear out_valid.
  - No new operand is accepted in the same cycle as the product handshake; the minimum issue interval is therefore 34 cycles (non-bypass) or 2 cycles (bypass).
- Latency, counted in edges after the accepting edge:
  - Non-bypass: out_valid rises after 32 edges.
  - Bypass: out_valid rises at the accepting edge itself, i.e. visible the next cycle.
- in_valid while in RUN or DONE is ignored; in_ready=0, so there is no handshake and the operands are not captured.
- out_p is 0 outside DONE. It is driven from registers, with no combinational path from in_* to out_*.
- Arithmetic: unsigned only. The adder's overflow output is unused. The carry-out is shifted into P_hi[WIDTH-1], so the product never loses bits.

Decomposition:
- Shared package mul_pkg:
  - state enum {IDLE, RUN, DONE} with 2-bit encoding;
  - WIDTH default constant;
  - CNT_W=6 constant.
- One sub-module: the existing 32-bit carry-increment adder, instantiated once inside seq_mul32 with no modification.
- The operand mux (M or 0) and the shift register stay in seq_mul32.

Test Plan:
- in_a=3, in_b=5, out_ready=1 -> out_valid rises 32 edges after accept; out_p=64'h0000_0000_0000_000F; busy high for exactly 32 cycles.
- in_a=in_b=32'hFFFF_FFFF -> out_p=64'hFFFF_FFFE_0000_0001; exercises adder carry-out into P_hi every iteration.
- ZERO_BYPASS=1, in_a=0, in_b=32'h1234_5678 -> out_valid one cycle after accept, out_p=0, busy never high. With ZERO_BYPASS=0, the same stimulus takes 32 cycles and yields 0.
- in_a=32'h8000_0001, in_b=32'h0000_0002, out_ready held 0 for 10 cycles after out_valid -> out_p=64'h0000_0001_0000_0002 stable throughout. in_valid pulses during RUN/DONE are ignored (in_ready=0); the next operands are accepted only after the product handshake.
- Start 7x9, drop rst_n low for one edge at iteration 15 -> all outputs at reset values next cycle, no out_valid. Then 7x9 again -> out_p=63 after 32 edges.
- Back-to-back: 10 random operand pairs with random out_ready stalls -> every out_p matches the reference product, in order.
